// File: rtl/text_term_writer.sv
// Terminal-style front end: turns an incoming byte stream into text-mode video RAM cell writes,
// tracking cursor and attribute and running hardware screen/line clears.
module text_term_writer #(
    parameter int unsigned COLS         = 30,
    parameter int unsigned ROWS         = 17,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h07,
    parameter logic [7:0]  FILL_CHAR    = 8'h20
) (
    input  logic        pxclk_i,
    input  logic        rstn_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        ram_we_o,
    output logic [9:0]  ram_addr_o,
    output logic [15:0] ram_data_o,
    output logic [4:0]  cur_row_o,
    output logic [4:0]  cur_col_o,
    output logic        busy_o
);

    localparam int unsigned POS_W  = 5;
    localparam int unsigned ADDR_W = 2 * POS_W;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned DATA_W = 2 * CHAR_W;

    localparam logic [POS_W-1:0] COL_LAST = POS_W'(COLS - 1);
    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(ROWS - 1);

    localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;
    localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
    localparam logic [CHAR_W-1:0] CH_FF    = 8'h0C;
    localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
    localparam logic [CHAR_W-1:0] CH_ESC   = 8'h1B;
    localparam logic [CHAR_W-1:0] PRINT_LO = 8'h20;
    localparam logic [CHAR_W-1:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ESC        = 2'd1,
        ST_CLR_SCREEN = 2'd2,
        ST_CLR_LINE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [POS_W-1:0]  row_q, row_nxt;
    logic [POS_W-1:0]  col_q, col_nxt;
    logic [POS_W-1:0]  clr_row_q, clr_row_nxt;
    logic [POS_W-1:0]  clr_col_q, clr_col_nxt;
    logic [CHAR_W-1:0] attr_q, attr_nxt;

    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              ready_nxt;
    logic              busy_nxt;

    logic              accept;
    logic              is_print;
    logic              col_at_end;
    logic              clr_col_end;
    logic              clr_row_end;
    logic [POS_W-1:0]  row_adv;
    logic              rx_state_now;
    logic              rx_state_next;

    assign accept      = valid_i & ready_o;
    assign is_print    = (data_i >= PRINT_LO) && (data_i <= PRINT_HI);
    assign col_at_end  = (col_q == COL_LAST);
    assign clr_col_end = (clr_col_q == COL_LAST);
    assign clr_row_end = (clr_row_q == ROW_LAST);
    // Cursor row step with wrap, no scrolling
    assign row_adv     = (row_q == ROW_LAST) ? '0 : row_q + POS_W'(1);

    assign rx_state_now  = (state == ST_IDLE) || (state == ST_ESC);
    assign rx_state_next = (state_nxt == ST_IDLE) || (state_nxt == ST_ESC);

    assign cur_row_o = row_q;
    assign cur_col_o = col_q;

    // State register
    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_CLR_SCREEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        if (col_at_end) begin
                            state_nxt = ST_CLR_LINE;
                        end
                    end else begin
                        case (data_i)
                            CH_LF:   state_nxt = ST_CLR_LINE;
                            CH_FF:   state_nxt = ST_CLR_SCREEN;
                            CH_ESC:  state_nxt = ST_ESC;
                            default: state_nxt = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_ESC: begin
                if (accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CLR_SCREEN: begin
                if (clr_col_end && clr_row_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CLR_LINE: begin
                if (clr_col_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_CLR_SCREEN;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        row_nxt     = row_q;
        col_nxt     = col_q;
        clr_row_nxt = clr_row_q;
        clr_col_nxt = clr_col_q;
        attr_nxt    = attr_q;
        we_nxt      = 1'b0;
        addr_nxt    = ram_addr_o;
        data_nxt    = ram_data_o;
        // Ready only once the previous cycle was already a receive state, so it
        // rises one cycle after the last clear write and drops as a clear starts
        ready_nxt   = rx_state_now && rx_state_next;
        busy_nxt    = !ready_nxt;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        we_nxt   = 1'b1;
                        addr_nxt = {row_q, col_q};
                        data_nxt = {attr_q, data_i};
                        if (col_at_end) begin
                            col_nxt     = '0;
                            row_nxt     = row_adv;
                            clr_row_nxt = row_adv;
                            clr_col_nxt = '0;
                        end else begin
                            col_nxt = col_q + POS_W'(1);
                        end
                    end else begin
                        case (data_i)
                            CH_CR: begin
                                col_nxt = '0;
                            end
                            CH_LF: begin
                                row_nxt     = row_adv;
                                clr_row_nxt = row_adv;
                                clr_col_nxt = '0;
                            end
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_nxt  = col_q - POS_W'(1);
                                    we_nxt   = 1'b1;
                                    addr_nxt = {row_q, col_q - POS_W'(1)};
                                    data_nxt = {attr_q, FILL_CHAR};
                                end
                            end
                            CH_FF: begin
                                row_nxt     = '0;
                                col_nxt     = '0;
                                clr_row_nxt = '0;
                                clr_col_nxt = '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            ST_ESC: begin
                if (accept) begin
                    attr_nxt = data_i;
                end
            end
            ST_CLR_SCREEN, ST_CLR_LINE: begin
                we_nxt   = 1'b1;
                addr_nxt = {clr_row_q, clr_col_q};
                data_nxt = {attr_q, FILL_CHAR};
                if (clr_col_end) begin
                    clr_col_nxt = '0;
                    if (state == ST_CLR_SCREEN) begin
                        clr_row_nxt = clr_row_end ? '0 : clr_row_q + POS_W'(1);
                    end
                end else begin
                    clr_col_nxt = clr_col_q + POS_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            row_q      <= '0;
            col_q      <= '0;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
            attr_q     <= DEFAULT_ATTR;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
        end else begin
            row_q      <= row_nxt;
            col_q      <= col_nxt;
            clr_row_q  <= clr_row_nxt;
            clr_col_q  <= clr_col_nxt;
            attr_q     <= attr_nxt;
            ram_we_o   <= we_nxt;
            ram_addr_o <= addr_nxt;
            ram_data_o <= data_nxt;
            ready_o    <= ready_nxt;
            busy_o     <= busy_nxt;
        end
    end

endmodule
